uart_rx_oversampled_receiver: RTL and testbench

//  UART receiver: the receive end of the 8-data/even-parity/1-stop link, 50 MHz Clk.

---
 rtl/uart_rx_oversampled_receiver.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_oversampled_receiver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled_receiver.sv
// 8E1 UART receiver with a per-baud 16x tick generator; byte, parity and framing flags pulse out with Rx_VALID.
// Optional `RX_MAJORITY_VOTE_EN: 2-of-3 vote over ticks 6,7,8 instead of a single sample at tick 7.
module uart_rx_oversampled_receiver #(
    parameter int CLK_HZ     = 50000000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    // Rounded divisor; yields 10417,2604,651,326,163,81,54,27 at 50 MHz.
    function automatic int div_for(input int baud);
        return (CLK_HZ + baud * OVERSAMPLE / 2) / (baud * OVERSAMPLE);
    endfunction

    localparam int DW = $clog2(div_for(300) + 1);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] LAST_IDX = TW'(OVERSAMPLE - 1);
`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [TW-1:0] DEC_IDX = TW'(OVERSAMPLE / 2);
`else
    localparam logic [TW-1:0] DEC_IDX = TW'(OVERSAMPLE / 2 - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      baud_sel_q;
    logic [DW-1:0]   div_q, div_d, div_last;
    logic [TW-1:0]   tidx_q, tidx_d;
    logic [2:0]      bidx_q, bidx_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            armed_q, armed_d;
    logic [1:0]      sync_q;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            rx_s;
    logic            tick;
    logic            decide;
    logic            last;
    logic            sample;

    assign rx_s = sync_q[1];

    always_comb begin
        div_last = '0;
        case (baud_sel_q)
            3'd0:    div_last = DW'(div_for(300) - 1);
            3'd1:    div_last = DW'(div_for(1200) - 1);
            3'd2:    div_last = DW'(div_for(4800) - 1);
            3'd3:    div_last = DW'(div_for(9600) - 1);
            3'd4:    div_last = DW'(div_for(19200) - 1);
            3'd5:    div_last = DW'(div_for(38400) - 1);
            3'd6:    div_last = DW'(div_for(57600) - 1);
            default: div_last = DW'(div_for(115200) - 1);
        endcase
    end

    assign tick   = (div_q == div_last);
    assign decide = tick && (tidx_q == DEC_IDX);
    assign last   = tick && (tidx_q == LAST_IDX);

`ifdef RX_MAJORITY_VOTE_EN
    logic s_a_q, s_b_q;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            s_a_q <= 1'b1;
            s_b_q <= 1'b1;
        end else begin
            if (tick && (tidx_q == DEC_IDX - TW'(2))) s_a_q <= rx_s;
            if (tick && (tidx_q == DEC_IDX - TW'(1))) s_b_q <= rx_s;
        end
    end

    assign sample = (s_a_q & s_b_q) | (s_a_q & rx_s) | (s_b_q & rx_s);
`else
    assign sample = rx_s;
`endif

    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + DW'(1);
        tidx_d  = tick ? tidx_q + TW'(1) : tidx_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        par_d   = par_q;
        // A framing error leaves the line low; wait for it to go high before re-arming.
        armed_d = armed_q | rx_s;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;

        if (baud_select != baud_sel_q) div_d = '0;

        if (!Rx_EN) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s && armed_q) begin
                        state_d = S_START;
                        div_d   = '0;
                        tidx_d  = '0;
                    end
                end
                S_START: begin
                    if (decide && sample) begin
                        state_d = S_IDLE;
                    end else if (last) begin
                        state_d = S_DATA;
                        bidx_d  = '0;
                    end
                end
                S_DATA: begin
                    if (decide) shift_d[bidx_q] = sample;
                    if (last) begin
                        if (bidx_q == 3'd7) state_d = S_PARITY;
                        else                bidx_d  = bidx_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (decide) par_d = sample;
                    if (last)   state_d = S_STOP;
                end
                S_STOP: begin
                    if (decide) begin
                        data_d  = shift_q;
                        perr_d  = (^shift_q) ^ par_q;
                        ferr_d  = ~sample;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                        if (!sample) armed_d = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            baud_sel_q <= '0;
            div_q      <= '0;
            tidx_q     <= '0;
            bidx_q     <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            armed_q    <= 1'b1;
            sync_q     <= 2'b11;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_sel_q <= baud_select;
            div_q      <= div_d;
            tidx_q     <= tidx_d;
            bidx_q     <= bidx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            armed_q    <= armed_d;
            sync_q     <= {sync_q[0], RxD};
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_PERROR = perr_q;
    assign Rx_FERROR = ferr_q;

endmodule

// File: tb/tb_uart_rx_oversampled_receiver.sv
// Directed bench for uart_rx_oversampled_receiver: frames are serialised here, expected bytes/flags queued on send.
module tb_uart_rx_oversampled_receiver;

    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] baud_select = 3'b111;
    logic       Rx_EN = 1'b1;
    logic       RxD = 1'b1;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    uart_rx_oversampled_receiver dut (
        .Clk        (Clk),
        .reset      (reset),
        .baud_select(baud_select),
        .Rx_EN      (Rx_EN),
        .RxD        (RxD),
        .Rx_DATA    (Rx_DATA),
        .Rx_VALID   (Rx_VALID),
        .Rx_PERROR  (Rx_PERROR),
        .Rx_FERROR  (Rx_FERROR)
    );

    always #10 Clk = ~Clk;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vld_cnt  = 0;
    int   exp_cnt  = 0;
    int   bit_clks = 432;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // glitch_at >= 0 inverts the line for 25 clocks starting that many clocks into the bit.
    task automatic drive_bit(input logic v, input int glitch_at);
        RxD = v;
        if (glitch_at >= 0) begin
            wait_clks(glitch_at);
            RxD = ~v;
            wait_clks(25);
            RxD = v;
            wait_clks(bit_clks - glitch_at - 25);
        end else begin
            wait_clks(bit_clks);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gbit);
        exp_t e;
        e.d  = d;
        e.pe = (^d) ^ p;
        e.fe = ~s;
        sb_q.push_back(e);
        exp_cnt++;
        drive_bit(1'b0, -1);
        for (int i = 0; i < 8; i++) drive_bit(d[i], (i == gbit) ? 205 : -1);
        drive_bit(p, -1);
        drive_bit(s, -1);
    endtask

    always @(negedge Clk) begin
        if (reset && Rx_VALID) begin
            vld_cnt++;
            check("valid_expected", (sb_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("rx_data", {24'd0, Rx_DATA}, {24'd0, e.d});
                check("rx_perror", {31'd0, Rx_PERROR}, {31'd0, e.pe});
                check("rx_ferror", {31'd0, Rx_FERROR}, {31'd0, e.fe});
            end
        end
    end

    initial begin
        // Power-on reset values
        wait_clks(5);
        check("rst_data", {24'd0, Rx_DATA}, 32'h0);
        check("rst_valid", {31'd0, Rx_VALID}, 32'h0);
        check("rst_perror", {31'd0, Rx_PERROR}, 32'h0);
        check("rst_ferror", {31'd0, Rx_FERROR}, 32'h0);
        reset = 1'b1;
        wait_clks(20);

        // Clean frame at 115200
        send_frame(8'hA5, 1'b0, 1'b1, -1);
        wait_clks(10);
        check("a5_count", vld_cnt, exp_cnt);

        // Reset in the middle of a frame
        RxD = 1'b0;
        wait_clks(bit_clks * 3);
        reset = 1'b0;
        wait_clks(3);
        check("midrst_data", {24'd0, Rx_DATA}, 32'h0);
        check("midrst_valid", {31'd0, Rx_VALID}, 32'h0);
        check("midrst_perror", {31'd0, Rx_PERROR}, 32'h0);
        check("midrst_ferror", {31'd0, Rx_FERROR}, 32'h0);
        RxD = 1'b1;
        wait_clks(3);
        reset = 1'b1;
        wait_clks(bit_clks);
        check("midrst_no_valid", vld_cnt, exp_cnt);

        // Parity error
        send_frame(8'h01, 1'b0, 1'b1, -1);
        wait_clks(10);
        check("perr_count", vld_cnt, exp_cnt);

        // False start: 100-clock low pulse
        RxD = 1'b0;
        wait_clks(100);
        RxD = 1'b1;
        wait_clks(600);
        check("false_start_count", vld_cnt, exp_cnt);
        check("false_start_data", {24'd0, Rx_DATA}, 32'h01);
        check("false_start_perror", {31'd0, Rx_PERROR}, 32'h1);

        // Rx_EN dropped during data bit 3
        drive_bit(1'b0, -1);
        drive_bit(1'b1, -1);
        drive_bit(1'b0, -1);
        drive_bit(1'b1, -1);
        RxD = 1'b0;
        wait_clks(200);
        Rx_EN = 1'b0;
        wait_clks(10);
        RxD = 1'b1;
        wait_clks(bit_clks);
        Rx_EN = 1'b1;
        wait_clks(20);
        check("abort_count", vld_cnt, exp_cnt);
        check("abort_data", {24'd0, Rx_DATA}, 32'h01);

        // Back-to-back frames
        send_frame(8'hFF, 1'b0, 1'b1, -1);
        send_frame(8'h00, 1'b0, 1'b1, -1);
        wait_clks(10);
        check("b2b_count", vld_cnt, exp_cnt);

`ifdef RX_MAJORITY_VOTE_EN
        send_frame(8'h55, 1'b0, 1'b1, 2);
        wait_clks(10);
        check("glitch_count", vld_cnt, exp_cnt);
`endif

        // Break: line held low well past one frame must give exactly one framing-error frame
        send_frame(8'h00, 1'b0, 1'b0, -1);
        wait_clks(bit_clks * 11);
        RxD = 1'b1;
        wait_clks(50);
        check("break_count", vld_cnt, exp_cnt);

        // Framing error at 9600
        baud_select = 3'b011;
        bit_clks    = 5216;
        wait_clks(10);
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        RxD = 1'b1;
        wait_clks(300);
        check("ferr_count", vld_cnt, exp_cnt);
        check("ferr_hold", {31'd0, Rx_FERROR}, 32'h1);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
